// File: rtl/mult_acc.sv
// Frame accumulator behind the 8x8 multiplier: sums LEN products per frame and
// hands the sum out via valid/ready. Define MULT_ACC_SAT_EN for saturating sums with an ovf flag.
module mult_acc #(
  parameter int unsigned LEN  = 8,
  parameter int unsigned ACCW = 19
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [15:0]     prod,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [ACCW-1:0] sum,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            ovf,
  output logic            busy
);

  localparam int unsigned CNTW = 8;
  localparam int unsigned SUMW = ACCW + 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [ACCW-1:0] acc, acc_nxt, acc_add, sum_nxt;
  logic [CNTW-1:0] cnt, cnt_nxt;
  logic            ovf_add, ovf_nxt;
  logic            in_ready_nxt, out_valid_nxt, busy_nxt;

`ifdef MULT_ACC_SAT_EN
  logic [SUMW-1:0] sum_wide;
  assign sum_wide = {1'b0, acc} + SUMW'(prod);

  // Once a carry is seen the accumulator pins at full scale for the rest of the frame.
  always_comb begin
    acc_add = sum_wide[ACCW-1:0];
    ovf_add = ovf;
    if (sum_wide[ACCW] || ovf) begin
      acc_add = '1;
      ovf_add = 1'b1;
    end
  end
`else
  assign acc_add = acc + ACCW'(prod);
  assign ovf_add = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      cnt       <= '0;
      sum       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      sum       <= sum_nxt;
      ovf       <= ovf_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next-state and registered-output logic; in_ready/busy follow the next state.
  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    cnt_nxt       = cnt;
    sum_nxt       = sum;
    ovf_nxt       = ovf;
    out_valid_nxt = out_valid;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_ACC;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
        end
      end
      S_ACC: begin
        if (in_valid && in_ready) begin
          acc_nxt = acc_add;
          ovf_nxt = ovf_add;
          cnt_nxt = cnt + CNTW'(1);
          if (cnt == LAST) begin
            state_nxt     = S_DONE;
            sum_nxt       = acc_add;
            out_valid_nxt = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_nxt     = S_IDLE;
          out_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    in_ready_nxt = (state_nxt == S_ACC);
    busy_nxt     = (state_nxt != S_IDLE);
  end

endmodule
